// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: turns EX/MEM load/store requests into single ready-strobed word-bus transfers.
// Defining LSU_MISALIGN_TRAP_EN traps misaligned LH/LHU/SH/LW/SW instead of issuing them aligned down.
//
// state | meaning
// IDLE  | waiting for a load or store from EX/MEM
// BUSY  | bus request outstanding, timeout counter running
// DONE  | result and flags valid for one cycle, pipeline advances
module mem_stage_lsu (
    input  logic        CLK,
    input  logic        RST,
    input  logic        memWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] aluResultM,
    input  logic [31:0] writeDataM,
    input  logic        busReady,
    input  logic [31:0] busRData,
    output logic        busReq,
    output logic        busWe,
    output logic [31:0] busAddr,
    output logic [31:0] busWData,
    output logic [3:0]  busByteEn,
    output logic [31:0] readDataM,
    output logic        stallM,
    output logic        errM,
    output logic        misalignM
);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t      state, state_next;
    logic [3:0]  tmo_cnt;
    logic [2:0]  fn3_q;
    logic [1:0]  off_q;
    logic [1:0]  off;
    logic        req, misalign, start, timeout;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign off = aluResultM[1:0];
    assign req = memWriteM | (ResultSrcM == 2'b01);

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        misalign = 1'b0;
        if (memWriteM) begin
            case (funct3M)
                3'b001:  misalign = off[0];
                3'b010:  misalign = (off != 2'b00);
                default: misalign = 1'b0;
            endcase
        end else begin
            case (funct3M)
                3'b001, 3'b101: misalign = off[0];
                3'b010:         misalign = (off != 2'b00);
                default:        misalign = 1'b0;
            endcase
        end
    end
`else
    assign misalign = 1'b0;
`endif

    assign start = (state == IDLE) && req && !misalign;
    // The count reaches 15 on this cycle; a busReady in the same cycle takes precedence.
    assign timeout = (state == BUSY) && !busReady && (tmo_cnt == 4'd14);

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req) state_next = misalign ? DONE : BUSY;
            BUSY:    if (busReady || timeout) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busReq = (state == BUSY);
        stallM = !RST && ((state == BUSY) || ((state == IDLE) && req));
    end

    always_comb begin
        case (funct3M)
            3'b000: begin
                st_be    = 4'b0001 << off;
                st_wdata = {4{writeDataM[7:0]}};
            end
            3'b001: begin
                st_be    = 4'b0011 << {off[1], 1'b0};
                st_wdata = {2{writeDataM[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = writeDataM;
            end
        endcase
    end

    always_comb begin
        ld_byte = busRData[{off_q, 3'b000} +: 8];
        ld_half = off_q[1] ? busRData[31:16] : busRData[15:0];
        case (fn3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = busRData;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            tmo_cnt   <= 4'd0;
            fn3_q     <= 3'd0;
            off_q     <= 2'd0;
            busWe     <= 1'b0;
            busAddr   <= 32'd0;
            busWData  <= 32'd0;
            busByteEn <= 4'd0;
            readDataM <= 32'd0;
            errM      <= 1'b0;
            misalignM <= 1'b0;
        end else begin
            errM      <= timeout;
            misalignM <= (state == IDLE) && req && misalign;
            if (start) begin
                tmo_cnt   <= 4'd0;
                fn3_q     <= funct3M;
                off_q     <= off;
                busWe     <= memWriteM;
                busAddr   <= {aluResultM[31:2], 2'b00};
                busWData  <= st_wdata;
                busByteEn <= memWriteM ? st_be : 4'b1111;
            end
            if (state == BUSY) begin
                if (busReady) begin
                    if (!busWe) readDataM <= ld_data;
                end else if (timeout) begin
                    if (!busWe) readDataM <= 32'd0;
                end else begin
                    tmo_cnt <= tmo_cnt + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: transaction-level reference model plus directed literal cases.
// Honours LSU_MISALIGN_TRAP_EN the same way the design does.
module tb_mem_stage_lsu;

    logic        CLK = 1'b0;
    logic        RST;
    logic        memWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  funct3M;
    logic [31:0] aluResultM;
    logic [31:0] writeDataM;
    logic        busReady;
    logic [31:0] busRData;
    logic        busReq, busWe, stallM, errM, misalignM;
    logic [31:0] busAddr, busWData, readDataM;
    logic [3:0]  busByteEn;

    mem_stage_lsu dut (
        .CLK(CLK), .RST(RST), .memWriteM(memWriteM), .ResultSrcM(ResultSrcM),
        .funct3M(funct3M), .aluResultM(aluResultM), .writeDataM(writeDataM),
        .busReady(busReady), .busRData(busRData), .busReq(busReq), .busWe(busWe),
        .busAddr(busAddr), .busWData(busWData), .busByteEn(busByteEn),
        .readDataM(readDataM), .stallM(stallM), .errM(errM), .misalignM(misalignM)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_pass = 0;

    logic        chk_en = 1'b0, chk_bus = 1'b0, chk_wd = 1'b0;
    logic        e_stall = 1'b0, e_req = 1'b0, e_err = 1'b0, e_mis = 1'b0, e_we = 1'b0;
    logic [3:0]  e_be = 4'd0;
    logic [31:0] e_addr = 32'd0, e_wd = 32'd0, e_rd = 32'd0, m_rd = 32'd0;

    logic [31:0] cap_addr, cap_wd, cap_rd;
    logic [3:0]  cap_be;
    logic        cap_we, cap_err, cap_mis;
    int          cap_stall, cap_busy;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("stallM", {31'd0, stallM}, {31'd0, e_stall});
            chk("busReq", {31'd0, busReq}, {31'd0, e_req});
            chk("errM", {31'd0, errM}, {31'd0, e_err});
            chk("misalignM", {31'd0, misalignM}, {31'd0, e_mis});
            chk("readDataM", readDataM, e_rd);
            if (chk_bus) begin
                chk("busAddr", busAddr, e_addr);
                chk("busWe", {31'd0, busWe}, {31'd0, e_we});
                chk("busByteEn", {28'd0, busByteEn}, {28'd0, e_be});
                if (chk_wd) chk("busWData", busWData, e_wd);
            end
        end
    end

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128) ? (b | 32'hFFFFFF00) : b;
            3'd4:    return b;
            3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF0000) : h;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] m_be(input logic we, input logic [2:0] f3, input logic [1:0] off);
        if (!we) return 4'hF;
        if (f3 == 3'd0) return 4'(32'd1 << off);
        if (f3 == 3'd1) return (off >= 2'd2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] wd);
        if (f3 == 3'd0) return (wd & 32'hFF) * 32'h01010101;
        if (f3 == 3'd1) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic m_mis(input logic we, input logic [2:0] f3, input logic [1:0] off);
`ifdef LSU_MISALIGN_TRAP_EN
        logic odd, nz;
        odd = (off % 2) != 0;
        nz  = off != 0;
        if (we) return (f3 == 3'd1 && odd) || (f3 == 3'd2 && nz);
        return ((f3 == 3'd1 || f3 == 3'd5) && odd) || (f3 == 3'd2 && nz);
`else
        return 1'b0 & we & f3[0] & off[0];
`endif
    endfunction

    // lat = BUSY cycle (1-based) carrying busReady; 0 means the bus never answers.
    task automatic run_txn(input logic we, input logic [1:0] rs, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                           input int lat);
        logic mis, tmo;
        int nb;
        mis = m_mis(we, f3, addr[1:0]);
        tmo = !mis && (lat == 0);
        nb  = mis ? 0 : (tmo ? 15 : lat);
        cap_stall = 0;
        cap_busy  = 0;
        for (int k = 0; k < nb + 2; k++) begin
            @(posedge CLK);
            #1;
            if (k == 0) begin
                memWriteM  = we;
                ResultSrcM = rs;
                funct3M    = f3;
                aluResultM = addr;
                writeDataM = wd;
            end
            if (k >= 1 && k <= nb) begin
                busReady = !tmo && (k == nb);
                busRData = busReady ? rd : 32'($urandom);
            end else begin
                busReady = 1'($urandom_range(0, 1));
                busRData = 32'($urandom);
            end
            e_req   = (k >= 1 && k <= nb);
            e_stall = (k <= nb);
            chk_bus = e_req;
            e_addr  = {addr[31:2], 2'b00};
            e_we    = we;
            e_be    = m_be(we, f3, addr[1:0]);
            e_wd    = m_wd(f3, wd);
            chk_wd  = we;
            e_err   = 1'b0;
            e_mis   = 1'b0;
            if (k == nb + 1) begin
                e_err = tmo;
                e_mis = mis;
                if (!mis && !we) m_rd = tmo ? 32'd0 : m_load(f3, addr[1:0], rd);
            end
            e_rd   = m_rd;
            chk_en = 1'b1;
            @(negedge CLK);
            if (stallM === 1'b1) cap_stall++;
            if (busReq === 1'b1) cap_busy++;
            if (k == 1) begin
                cap_addr = busAddr;
                cap_we   = busWe;
                cap_be   = busByteEn;
                cap_wd   = busWData;
            end
            if (k == nb + 1) begin
                cap_rd  = readDataM;
                cap_err = errM;
                cap_mis = misalignM;
            end
        end
        #1;
    endtask

    task automatic idle_cycles(input int n);
        int r;
        for (int k = 0; k < n; k++) begin
            @(posedge CLK);
            #1;
            r          = $urandom_range(0, 2);
            memWriteM  = 1'b0;
            ResultSrcM = (r == 0) ? 2'b00 : ((r == 1) ? 2'b10 : 2'b11);
            funct3M    = 3'($urandom);
            aluResultM = 32'($urandom);
            busReady   = 1'($urandom_range(0, 1));
            busRData   = 32'($urandom);
            e_req = 1'b0; e_stall = 1'b0; chk_bus = 1'b0;
            e_err = 1'b0; e_mis = 1'b0; e_rd = m_rd;
            @(negedge CLK);
        end
    endtask

    initial begin
        logic        we;
        logic [1:0]  rs;
        int          lat;
        logic [31:0] r_busreq, r_rd, r_rd2;

        RST = 1'b1; memWriteM = 1'b1; ResultSrcM = 2'b00; funct3M = 3'd2;
        aluResultM = 32'h44; writeDataM = 32'h1; busReady = 1'b1; busRData = 32'h5;
        @(posedge CLK);
        #1;
        e_stall = 1'b0; e_req = 1'b0; e_err = 1'b0; e_mis = 1'b0; e_rd = 32'd0;
        chk_bus = 1'b1; chk_wd = 1'b1; e_addr = 32'd0; e_we = 1'b0; e_be = 4'd0; e_wd = 32'd0;
        chk_en = 1'b1;
        @(negedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b0; memWriteM = 1'b0; busReady = 1'b0; chk_bus = 1'b0;
        @(negedge CLK);

        run_txn(1'b1, 2'b00, 3'd2, 32'h104, 32'hDEADBEEF, 32'h0, 2);
        chk("sw_addr", cap_addr, 32'h104);
        chk("sw_be", {28'd0, cap_be}, 32'hF);
        chk("sw_we", {31'd0, cap_we}, 32'd1);
        chk("sw_wdata", cap_wd, 32'hDEADBEEF);
        chk("sw_stall_cycles", cap_stall, 3);

        run_txn(1'b0, 2'b01, 3'd0, 32'h203, 32'h0, 32'h80FF0000, 1);
        chk("lb_data", cap_rd, 32'hFFFFFF80);
        run_txn(1'b0, 2'b01, 3'd4, 32'h203, 32'h0, 32'h80FF0000, 1);
        chk("lbu_data", cap_rd, 32'h00000080);

        run_txn(1'b1, 2'b00, 3'd1, 32'h12, 32'h0000ABCD, 32'h0, 1);
        chk("sh_be", {28'd0, cap_be}, 32'hC);
        chk("sh_wdata", cap_wd, 32'hABCDABCD);

        run_txn(1'b0, 2'b01, 3'd2, 32'h300, 32'h0, 32'h11111111, 0);
        chk("tmo_err", {31'd0, cap_err}, 32'd1);
        chk("tmo_data", cap_rd, 32'd0);
        chk("tmo_busy_cycles", cap_busy, 15);
        chk("tmo_stall_cycles", cap_stall, 16);

        run_txn(1'b0, 2'b01, 3'd2, 32'h304, 32'h0, 32'h0BADCAFE, 15);
        chk("late_ready_err", {31'd0, cap_err}, 32'd0);
        chk("late_ready_data", cap_rd, 32'h0BADCAFE);
        chk("late_ready_busy", cap_busy, 15);

        run_txn(1'b0, 2'b01, 3'd2, 32'h101, 32'h0, 32'hCAFEF00D, 1);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("mis_busreq", cap_busy, 0);
        chk("mis_flag", {31'd0, cap_mis}, 32'd1);
        chk("mis_stall", cap_stall, 1);
        chk("mis_data_held", cap_rd, 32'h0BADCAFE);
`else
        chk("mis_addr", cap_addr, 32'h100);
        chk("mis_data", cap_rd, 32'hCAFEF00D);
        chk("mis_stall", cap_stall, 2);
        chk("mis_flag", {31'd0, cap_mis}, 32'd0);
`endif

        run_txn(1'b0, 2'b01, 3'd2, 32'h80, 32'h0, 32'h55AA1234, 1);
        chk("lw_data", cap_rd, 32'h55AA1234);

        @(posedge CLK);
        #1;
        memWriteM = 1'b0; ResultSrcM = 2'b01; funct3M = 3'd2; aluResultM = 32'h48; busReady = 1'b0;
        e_req = 1'b0; e_stall = 1'b1; chk_bus = 1'b0; e_err = 1'b0; e_mis = 1'b0; e_rd = m_rd;
        @(negedge CLK);
        @(posedge CLK);
        #1;
        e_req = 1'b1; chk_bus = 1'b1; e_addr = 32'h48; e_we = 1'b0; e_be = 4'hF; chk_wd = 1'b0;
        @(negedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b1; e_stall = 1'b0;
        @(negedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b0; memWriteM = 1'b0; ResultSrcM = 2'b00; busReady = 1'b1; busRData = 32'h12345678;
        m_rd = 32'd0; e_rd = 32'd0; e_req = 1'b0; e_stall = 1'b0;
        chk_bus = 1'b1; e_addr = 32'd0; e_we = 1'b0; e_be = 4'd0; chk_wd = 1'b1; e_wd = 32'd0;
        @(negedge CLK);
        r_busreq = {31'd0, busReq};
        r_rd     = readDataM;
        @(posedge CLK);
        #1;
        busReady = 1'b0; chk_bus = 1'b0;
        @(negedge CLK);
        r_rd2 = readDataM;
        #1;
        chk("rst_busreq", r_busreq, 32'd0);
        chk("rst_data", r_rd, 32'd0);
        chk("rst_data_late", r_rd2, 32'd0);

        for (int i = 0; i < 120; i++) begin
            we  = 1'($urandom_range(0, 1));
            rs  = we ? 2'($urandom_range(0, 3)) : 2'b01;
            lat = ($urandom_range(0, 11) == 0) ? 0 :
                  (($urandom_range(0, 11) == 0) ? 15 : int'($urandom_range(1, 4)));
            run_txn(we, rs, 3'($urandom), 32'($urandom), 32'($urandom), 32'($urandom), lat);
            idle_cycles(int'($urandom_range(0, 2)));
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
